// File: rtl/lenet_pkg.sv
// Shared types and default sizing for the LeNet inference scheduler slice.
package lenet_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    SCAN  = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

  localparam int DEF_IMG_DIM        = 28;
  localparam int DEF_NUM_CLASSES    = 10;
  localparam int DEF_BITWIDTH       = 9;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lenet_argmax_seq.sv
// Serial signed argmax: one score per valid cycle; winner is registered on the last one.
module lenet_argmax_seq
  import lenet_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int IW       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       score_valid,
  input  logic                       score_first,
  input  logic                       score_last,
  input  logic [IW-1:0]              score_idx,
  input  logic signed [BITWIDTH-1:0] score_val,
  output logic [IW-1:0]              win_idx,
  output logic signed [BITWIDTH-1:0] win_val,
  output logic                       win_hit
);

  logic [IW-1:0]              best_idx_r;
  logic signed [BITWIDTH-1:0] best_val_r;
  logic [IW-1:0]              cand_idx_s;
  logic signed [BITWIDTH-1:0] cand_val_s;
  logic [IW-1:0]              win_idx_r;
  logic signed [BITWIDTH-1:0] win_val_r;
  logic                       win_hit_r;

  // Candidate after this score; strict greater keeps the lowest index on ties.
  always_comb begin
    cand_idx_s = best_idx_r;
    cand_val_s = best_val_r;
    if (score_first || (score_val > best_val_r)) begin
      cand_idx_s = score_idx;
      cand_val_s = score_val;
    end else begin
      cand_idx_s = best_idx_r;
      cand_val_s = best_val_r;
    end
  end

  // Running best plus the published winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_idx_r <= '0;
      best_val_r <= '0;
      win_idx_r  <= '0;
      win_val_r  <= '0;
      win_hit_r  <= 1'b0;
    end else if (score_valid) begin
      best_idx_r <= cand_idx_s;
      best_val_r <= cand_val_s;
      if (score_last) begin
        win_idx_r <= cand_idx_s;
        win_val_r <= cand_val_s;
        win_hit_r <= 1'b1;
      end
    end
  end

  assign win_idx = win_idx_r;
  assign win_val = win_val_r;
  assign win_hit = win_hit_r;

endmodule

// File: rtl/lenet_inference_scheduler.sv
// Frame loader, accelerator start/timeout sequencer and serial argmax result port
// for one LeNet inference.
module lenet_inference_scheduler
  import lenet_pkg::*;
#(
  parameter  int BITWIDTH       = DEF_BITWIDTH,
  parameter  int IMG_DIM        = DEF_IMG_DIM,
  parameter  int NUM_CLASSES    = DEF_NUM_CLASSES,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int RW             = clog2_min1(IMG_DIM),
  localparam int CW             = clog2_min1(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [BITWIDTH-1:0]    pix_data,
  input  logic                   pix_last,
  output logic                   img_we,
  output logic [RW-1:0]          img_row,
  output logic [RW-1:0]          img_col,
  output logic [BITWIDTH-1:0]    img_wdata,
  output logic                   acc_start,
  input  logic                   acc_done,
  output logic [CW-1:0]          score_idx,
  input  logic [BITWIDTH-1:0]    score_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CW-1:0]          res_class,
  output logic [BITWIDTH-1:0]    res_score,
  output logic [NUM_CLASSES-1:0] led,
  output logic                   busy,
  output logic                   err_frame,
  output logic                   err_timeout
);

  localparam int              TW       = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [RW-1:0]   DIM_LAST = RW'(IMG_DIM - 1);
  localparam logic [CW-1:0]   CLS_LAST = CW'(NUM_CLASSES - 1);

  sched_state_t               state_r, state_s;
  logic [RW-1:0]              row_r, col_r;
  logic [CW-1:0]              scan_r;
  logic [TW-1:0]              tmo_r;
  logic                       err_frame_r, err_timeout_r;
  logic                       xfer_s, frame_end_s, tmo_hit_s;
  logic [CW-1:0]              win_idx_s;
  logic signed [BITWIDTH-1:0] win_val_s;
  logic                       win_hit_s;

  assign frame_end_s = (row_r == DIM_LAST) && (col_r == DIM_LAST);
  assign tmo_hit_s   = (TIMEOUT_CYCLES > 0) && (tmo_r == TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, LOAD: begin
        if (!xfer_s) begin
          state_s = state_r;
        end else if (frame_end_s) begin
          state_s = START;
        end else if (pix_last) begin
          state_s = IDLE;
        end else begin
          state_s = LOAD;
        end
      end
      START: state_s = WAIT;
      WAIT: begin
        // acc_done on the last allowed cycle beats the timeout.
        if (acc_done) begin
          state_s = SCAN;
        end else if (tmo_hit_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      SCAN: begin
        if (scan_r == CLS_LAST) begin
          state_s = DONE;
        end else begin
          state_s = SCAN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode; pixel accept and start are held off while reset is asserted.
  always_comb begin
    pix_ready = 1'b0;
    acc_start = 1'b0;
    case (state_r)
      IDLE, LOAD: pix_ready = ~reset;
      START:      acc_start = ~reset;
      default: begin
        pix_ready = 1'b0;
        acc_start = 1'b0;
      end
    endcase
    xfer_s    = pix_ready & pix_valid;
    img_we    = xfer_s;
    img_row   = row_r;
    img_col   = col_r;
    img_wdata = pix_data;
    score_idx = scan_r;
    res_valid = (state_r == DONE);
    busy      = (state_r != IDLE);
  end

  // Frame, scan and timeout counters plus sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_r         <= '0;
      col_r         <= '0;
      scan_r        <= '0;
      tmo_r         <= '0;
      err_frame_r   <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, LOAD: begin
          if (xfer_s) begin
            if (frame_end_s || pix_last) begin
              row_r <= '0;
              col_r <= '0;
            end else if (col_r == DIM_LAST) begin
              col_r <= '0;
              row_r <= row_r + RW'(1);
            end else begin
              col_r <= col_r + RW'(1);
            end
            // The first pixel of a frame clears both sticky flags.
            err_frame_r <= ((state_r == IDLE) ? 1'b0 : err_frame_r)
                         | (frame_end_s ? ~pix_last : pix_last);
            if (state_r == IDLE) begin
              err_timeout_r <= 1'b0;
            end
          end
        end
        START: begin
          tmo_r  <= '0;
          scan_r <= '0;
        end
        WAIT: begin
          if (acc_done || tmo_hit_s) begin
            tmo_r <= '0;
          end else if (TIMEOUT_CYCLES > 0) begin
            tmo_r <= tmo_r + TW'(1);
          end
          if (!acc_done && tmo_hit_s) begin
            err_timeout_r <= 1'b1;
          end
        end
        SCAN: scan_r <= (scan_r == CLS_LAST) ? '0 : scan_r + CW'(1);
        default: ;
      endcase
    end
  end

  lenet_argmax_seq #(
    .BITWIDTH (BITWIDTH),
    .IW       (CW)
  ) u_argmax (
    .clk         (clk),
    .reset       (reset),
    .score_valid (state_r == SCAN),
    .score_first (scan_r == '0),
    .score_last  (scan_r == CLS_LAST),
    .score_idx   (scan_r),
    .score_val   ($signed(score_data)),
    .win_idx     (win_idx_s),
    .win_val     (win_val_s),
    .win_hit     (win_hit_s)
  );

  // LED is dark until the first result has been produced.
  always_comb begin
    led = '0;
    if (win_hit_s) begin
      led[win_idx_s] = 1'b1;
    end else begin
      led = '0;
    end
  end

  assign res_class   = win_idx_s;
  assign res_score   = win_val_s;
  assign err_frame   = err_frame_r;
  assign err_timeout = err_timeout_r;

endmodule
